// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads a combinational ROM, and holds
// one fetched word in a buffer that decode drains over a valid/ready handshake.
module fetch_controller #(
    parameter int              PC_W         = 32,
    parameter int              IMEM_AW      = 5,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter bit              HALT_ON_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               redir_valid,
    input  logic [PC_W-1:0]    redir_pc,
    output logic               halted,
    output logic [1:0]         fault,
    output logic [1:0]         dbg_state,
    output logic [PC_W-1:0]    dbg_pc
);

    // Handshake: if_instr/if_pc are consumed on any cycle where if_valid && if_ready;
    // while if_valid && !if_ready they are held stable. A redirect flushes the buffer.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    // PC is always word aligned, so only the word index is stored.
    logic [PC_W-3:0]    r_pc_w;
    logic               r_if_valid;
    logic [31:0]        r_if_instr;
    logic [PC_W-1:0]    r_if_pc;
    logic [1:0]         r_fault;

    logic               w_fetch_slot;
    logic               w_out_of_range;
    logic               w_zero_word;
    logic               w_capture;
    logic               w_transfer;

    assign w_transfer     = r_if_valid && if_ready;
    assign w_fetch_slot   = (r_state == ST_RUN) && !redir_valid && (!r_if_valid || if_ready);
    assign w_out_of_range = |r_pc_w[PC_W-3:IMEM_AW];
    assign w_zero_word    = HALT_ON_ZERO && (imem_rdata == 32'h0);
    assign w_capture      = w_fetch_slot && !w_out_of_range && !w_zero_word;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_fetch_slot && (w_out_of_range || w_zero_word)) w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (redir_valid) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc_w     <= RESET_PC[PC_W-1:2];
            r_if_valid <= 1'b0;
            r_if_instr <= 32'h0;
            r_if_pc    <= '0;
            r_fault    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;

            if (redir_valid) begin
                r_pc_w     <= redir_pc[PC_W-1:2];
                r_if_valid <= 1'b0;
            end else if (w_capture) begin
                r_pc_w     <= r_pc_w + 1'b1;
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata;
                r_if_pc    <= {r_pc_w, 2'b00};
            end else if (w_transfer) begin
                r_if_valid <= 1'b0;
            end

            if (redir_valid && (redir_pc[1:0] != 2'b00)) r_fault[0] <= 1'b1;
            if (w_fetch_slot && w_out_of_range)          r_fault[1] <= 1'b1;
        end
    end

    assign imem_addr = r_pc_w[IMEM_AW-1:0];
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign halted    = (r_state == ST_HALT);
    assign fault     = r_fault;
    assign dbg_state = r_state;
    assign dbg_pc    = {r_pc_w, 2'b00};

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: stimulus pushes expected {pc, instr} words,
// a negedge monitor pops and compares on every handshake.
module tb_fetch_controller;

  localparam int PC_W    = 32;
  localparam int IMEM_AW = 5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               if_valid;
  logic               if_ready = 1'b0;
  logic [31:0]        if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               redir_valid = 1'b0;
  logic [PC_W-1:0]    redir_pc = '0;
  logic               halted;
  logic [1:0]         fault;
  logic [1:0]         dbg_state;
  logic [PC_W-1:0]    dbg_pc;

  logic [31:0] rom [32];
  logic [63:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  assign imem_rdata = rom[imem_addr];

  fetch_controller #(
    .PC_W(PC_W), .IMEM_AW(IMEM_AW), .RESET_PC('0), .HALT_ON_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halted(halted), .fault(fault), .dbg_state(dbg_state), .dbg_pc(dbg_pc)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got pc=0x%0h instr=0x%0h with empty queue", if_pc, if_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({if_pc, if_instr} !== e) begin
          n_err++;
          $display("FAIL issue: got pc=0x%0h instr=0x%0h expected pc=0x%0h instr=0x%0h",
                   if_pc, if_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      logic [31:0] a;
      a = k * 4;
      exp_q.push_back({a, rom[k]});
    end
  endtask

  task automatic wait_halt(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!halted && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, {63'd0, halted}, 64'd1);
  endtask

  // Redirect with decode stalled: buffer flushed at once, target word two cycles later.
  task automatic redirect(input string name, input logic [31:0] target, input logic [31:0] exp_pc);
    if_ready    = 1'b0;
    redir_pc    = target;
    redir_valid = 1'b1;
    tick();
    redir_valid = 1'b0;
    check({name, "_flush"}, {63'd0, if_valid}, 64'd0);
    check({name, "_pc"}, dbg_pc, exp_pc);
    tick();
    check({name, "_valid"}, {63'd0, if_valid}, 64'd1);
    check({name, "_if_pc"}, if_pc, exp_pc);
    check({name, "_instr"}, if_instr, rom[exp_pc[6:2]]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | i;
    rom[5]  = 32'h0;
    rom[12] = 32'h0;

    // reset state
    #12;
    check("rst_valid", {63'd0, if_valid}, 64'd0);
    check("rst_instr", if_instr, 64'd0);
    check("rst_if_pc", if_pc, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_fault", fault, 64'd0);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_pc", dbg_pc, 64'd0);
    tick();
    rst = 1'b0;
    if_ready = 1'b1;
    repeat (3) tick();
    check("idle_no_fetch", {63'd0, if_valid}, 64'd0);

    // 1: straight-line run halts on zero word 5
    push_words(0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_run", dbg_state, S_RUN);
    wait_halt("t1_halt", 30);
    check("t1_pc", dbg_pc, 64'h14);
    check("t1_drained", exp_q.size(), 64'd0);
    check("t1_valid", {63'd0, if_valid}, 64'd0);

    // 2: stall holds buffer and pc
    rom[5] = 32'hA000_0005;
    redirect("t2_redir", 32'h8, 32'h8);
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_pc", if_pc, 64'h8);
      check("t2_hold_instr", if_instr, rom[2]);
      check("t2_hold_fetch_pc", dbg_pc, 64'hC);
      tick();
    end
    push_words(2, 3);
    if_ready = 1'b1;
    tick();
    check("t2_next_pc", if_pc, 64'hC);
    tick();
    if_ready = 1'b0;
    check("t2_buf", if_pc, 64'h10);

    // 3: redirect flushes the pending 0x10 word
    redirect("t3_redir", 32'h20, 32'h20);
    push_words(8, 11);
    if_ready = 1'b1;
    wait_halt("t3_halt", 30);
    check("t3_pc", dbg_pc, 64'h30);
    check("t3_drained", exp_q.size(), 64'd0);

    // 4: misaligned redirect
    redirect("t4_redir", 32'h1A, 32'h18);
    check("t4_fault", fault, 64'h1);

    // 5: run off the end of the ROM, then recover by redirect
    redirect("t5_redir", 32'h70, 32'h70);
    push_words(28, 31);
    if_ready = 1'b1;
    wait_halt("t5_halt", 30);
    check("t5_fault", fault, 64'h3);
    check("t5_pc", dbg_pc, 64'h80);
    check("t5_no_capture", if_pc, 64'h7C);
    check("t5_valid", {63'd0, if_valid}, 64'd0);
    check("t5_drained", exp_q.size(), 64'd0);
    redirect("t5_recover", 32'h4, 32'h4);
    check("t5_running", {63'd0, halted}, 64'd0);
    push_words(1, 11);
    if_ready = 1'b1;
    wait_halt("t5b_halt", 40);
    check("t5b_pc", dbg_pc, 64'h30);
    check("t5b_fault_sticky", fault, 64'h3);
    check("t5b_drained", exp_q.size(), 64'd0);

    // 6: asynchronous reset mid-run
    redirect("t6_redir", 32'h0, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid", {63'd0, if_valid}, 64'd0);
    check("t6_state", dbg_state, S_IDLE);
    check("t6_pc", dbg_pc, 64'd0);
    check("t6_fault", fault, 64'd0);
    check("t6_halted", {63'd0, halted}, 64'd0);
    tick();
    rst = 1'b0;
    redir_pc = 32'h10;
    redir_valid = 1'b1;
    tick();
    redir_valid = 1'b0;
    check("t6_idle_redir_state", dbg_state, S_IDLE);
    check("t6_idle_redir_pc", dbg_pc, 64'h10);
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle_no_fetch", {63'd0, if_valid}, 64'd0);
    end
    push_words(4, 11);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_halt("t6_halt", 30);
    check("t6_end_pc", dbg_pc, 64'h30);
    check("t6_drained", exp_q.size(), 64'd0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
